cpu_state_checker: RTL and testbench

//  Synthesizable self-checking harness for the 5-stage MIPS CPU. Runs the CPU for a
//  set number of cycles, then freezes it, walks the register file and the data

---
 rtl/cpu_state_checker_if.sv | 22 ++
 rtl/cpu_state_checker.sv | 132 +++++++++++++
 tb/tb_cpu_state_checker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_state_checker_if.sv
// Scan read port between the state checker and the CPU register file,
// data memory and expected-image memory.
interface cpu_state_checker_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 6
);
  logic             scan_sel;
  logic [IDX_W-1:0] scan_addr;
  logic [IDX_W-1:0] exp_addr;
  logic [WIDTH-1:0] act_data;
  logic [WIDTH-1:0] exp_data;

  modport master (
    output scan_sel, scan_addr, exp_addr,
    input  act_data, exp_data
  );

  modport slave (
    input  scan_sel, scan_addr, exp_addr,
    output act_data, exp_data
  );
endinterface

// File: rtl/cpu_state_checker.sv
// Runs the CPU for a fixed number of cycles, then freezes it and compares the
// register file and data memory against an expected image through a shared read port.
module cpu_state_checker #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned N_REGS       = 32,
  parameter int unsigned DMEM_DEPTH   = 32,
  parameter int unsigned RUN_CYCLES   = 26,
  parameter int unsigned STOP_ON_FAIL = 0,
  parameter int unsigned CNT_W        = 8,
  localparam int unsigned IDX_W       = $clog2(N_REGS + DMEM_DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                cpu_hold,
  cpu_state_checker_if.master scan,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    fail_count,
  output logic [IDX_W-1:0]    first_fail
);

  localparam int unsigned N_IDX = N_REGS + DMEM_DEPTH;
  localparam int unsigned CYC_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IDX - 1);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SCAN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
  logic [CNT_W-1:0] fail_d;
  logic [IDX_W-1:0] first_d;
  logic             sel_d;
  logic [IDX_W-1:0] addr_d;
  logic             mismatch;

  assign scan.exp_addr = idx_q;

  // Next-state, compare pipeline and scan address decode
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    idx_d     = idx_q;
    cmp_vld_d = 1'b0;
    cmp_idx_d = cmp_idx_q;
    fail_d    = fail_count;
    first_d   = first_fail;
    mismatch  = cmp_vld_q && (scan.act_data != scan.exp_data);

    if (mismatch) begin
      if (fail_count != '1) fail_d = fail_count + CNT_W'(1);
      if (fail_count == '0) first_d = cmp_idx_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          fail_d  = '0;
          first_d = '0;
          cyc_d   = '0;
          idx_d   = '0;
          state_d = (RUN_CYCLES == 0) ? S_SCAN : S_RUN;
        end
      end
      S_RUN: begin
        if (cyc_q == LAST_CYC) state_d = S_SCAN;
        else                   cyc_d   = cyc_q + CYC_W'(1);
      end
      S_SCAN: begin
        // Data for idx_q returns next cycle, so its compare is queued here
        if ((STOP_ON_FAIL != 0) && mismatch) begin
          state_d = S_DONE;
        end else begin
          cmp_vld_d = 1'b1;
          cmp_idx_d = idx_q;
          if (idx_q == LAST_IDX) state_d = S_FLUSH;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    sel_d  = (32'(idx_d) >= N_REGS);
    addr_d = sel_d ? IDX_W'(32'(idx_d) - N_REGS) : idx_d;
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cyc_q          <= '0;
      idx_q          <= '0;
      cmp_vld_q      <= 1'b0;
      cmp_idx_q      <= '0;
      fail_count     <= '0;
      first_fail     <= '0;
      cpu_hold       <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      scan.scan_sel  <= 1'b0;
      scan.scan_addr <= '0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      idx_q          <= idx_d;
      cmp_vld_q      <= cmp_vld_d;
      cmp_idx_q      <= cmp_idx_d;
      fail_count     <= fail_d;
      first_fail     <= first_d;
      cpu_hold       <= (state_d != S_RUN);
      busy           <= (state_d == S_RUN) || (state_d == S_SCAN) || (state_d == S_FLUSH);
      done           <= (state_d == S_DONE);
      pass           <= (state_d == S_DONE) && (fail_d == '0);
      scan.scan_sel  <= sel_d;
      scan.scan_addr <= addr_d;
    end
  end

endmodule

// File: tb/tb_cpu_state_checker.sv
// Directed bench for cpu_state_checker: three configurations driven against
// fake register/memory/expected arrays, results checked through a scoreboard queue.
module tb_cpu_state_checker;

  localparam int unsigned W  = 32;
  localparam int unsigned IW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] start;
  wire  [2:0] hold, busy, done, pass;
  wire  [7:0] fc0, fc1;
  wire  [1:0] fc2;
  wire  [IW-1:0] ff0, ff1, ff2;

  cpu_state_checker_if #(.WIDTH(W), .IDX_W(IW)) sb0 ();
  cpu_state_checker_if #(.WIDTH(W), .IDX_W(IW)) sb1 ();
  cpu_state_checker_if #(.WIDTH(W), .IDX_W(IW)) sb2 ();

  cpu_state_checker #(.RUN_CYCLES(26)) u0 (
    .clock(clk), .reset(reset), .start(start[0]), .cpu_hold(hold[0]), .scan(sb0.master),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_count(fc0), .first_fail(ff0));

  cpu_state_checker #(.RUN_CYCLES(0), .STOP_ON_FAIL(1)) u1 (
    .clock(clk), .reset(reset), .start(start[1]), .cpu_hold(hold[1]), .scan(sb1.master),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_count(fc1), .first_fail(ff1));

  cpu_state_checker #(.RUN_CYCLES(4), .CNT_W(2)) u2 (
    .clock(clk), .reset(reset), .start(start[2]), .cpu_hold(hold[2]), .scan(sb2.master),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .fail_count(fc2), .first_fail(ff2));

  // Actual arrays by flat index (regs 0..31, mem 32..63) and expected images
  logic [W-1:0] act_img [3][64];
  logic [W-1:0] exp_img [3][64];

  function automatic int flat(input logic sel, input logic [IW-1:0] addr);
    return sel ? 32 + int'(addr) : int'(addr);
  endfunction

  always @(posedge clk) begin
    sb0.act_data <= act_img[0][flat(sb0.scan_sel, sb0.scan_addr)];
    sb0.exp_data <= exp_img[0][sb0.exp_addr];
    sb1.act_data <= act_img[1][flat(sb1.scan_sel, sb1.scan_addr)];
    sb1.exp_data <= exp_img[1][sb1.exp_addr];
    sb2.act_data <= act_img[2][flat(sb2.scan_sel, sb2.scan_addr)];
    sb2.exp_data <= exp_img[2][sb2.exp_addr];
  end

  logic [7:0]    fc_v [3];
  logic [IW-1:0] ff_v [3];
  logic [IW-1:0] ea_v [3];
  always_comb begin
    fc_v[0] = fc0;  fc_v[1] = fc1;  fc_v[2] = {6'd0, fc2};
    ff_v[0] = ff0;  ff_v[1] = ff1;  ff_v[2] = ff2;
    ea_v[0] = sb0.exp_addr;  ea_v[1] = sb1.exp_addr;  ea_v[2] = sb2.exp_addr;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  typedef struct {
    int lat;
    int holdc;
    int fc;
    int ff;
    int ps;
    int maxi;
  } exp_t;

  exp_t sb_q [$];

  task automatic set_clean(input int k);
    for (int i = 0; i < 64; i++) begin
      act_img[k][i] = W'(i);
      exp_img[k][i] = W'(i);
    end
  endtask

  // Launch one run on instance k, then compare its outcome against the queued expectation
  task automatic run(input string tag, input int k, input int restart_at,
                     input int lat, input int holdc, input int fc, input int ff,
                     input int ps, input int maxi);
    exp_t e, got;
    int   cyc;
    e.lat = lat; e.holdc = holdc; e.fc = fc; e.ff = ff; e.ps = ps; e.maxi = maxi;
    sb_q.push_back(e);
    @(negedge clk);
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    start[k]  = 1'b0;
    cyc       = 0;
    got.holdc = hold[k] ? 0 : 1;
    got.maxi  = busy[k] ? int'(ea_v[k]) : 0;
    while (!done[k] && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      start[k] = (cyc == restart_at);
      if (!hold[k]) got.holdc++;
      if (busy[k] && int'(ea_v[k]) > got.maxi) got.maxi = int'(ea_v[k]);
    end
    start[k] = 1'b0;
    got.lat  = cyc;
    e = sb_q.pop_front();
    check({tag, "_done"},    32'(done[k]), 32'd1);
    check({tag, "_latency"}, 32'(got.lat), 32'(e.lat));
    check({tag, "_runcyc"},  32'(got.holdc), 32'(e.holdc));
    check({tag, "_count"},   32'(fc_v[k]), 32'(e.fc));
    check({tag, "_first"},   32'(ff_v[k]), 32'(e.ff));
    check({tag, "_pass"},    32'(pass[k]), 32'(e.ps));
    check({tag, "_maxidx"},  32'(got.maxi), 32'(e.maxi));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_done"}, 32'(done[k]), 32'd1);
    check({tag, "_hold_pass"}, 32'(pass[k]), 32'(e.ps));
    check({tag, "_frozen"},    32'(hold[k]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    reset = 1'b1;
    start = '0;
    for (int k = 0; k < 3; k++) set_clean(k);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold",  32'(hold[0]), 32'd1);
    check("rst_busy",  32'(busy[0]), 32'd0);
    check("rst_done",  32'(done[0]), 32'd0);
    check("rst_pass",  32'(pass[0]), 32'd0);
    check("rst_count", 32'(fc_v[0]), 32'd0);
    check("rst_first", 32'(ff_v[0]), 32'd0);
    check("rst_sel",   32'(sb0.scan_sel), 32'd0);
    check("rst_saddr", 32'(sb0.scan_addr), 32'd0);
    check("rst_eaddr", 32'(sb0.exp_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Clean image: full scan passes after RUN_CYCLES + 65 clocks
    run("t1_clean", 0, -1, 91, 26, 0, 0, 1, 63);

    // Register 2 holds 27, image expects 28
    exp_img[0][2] = 28; act_img[0][2] = 27;
    run("t2_reg2", 0, -1, 91, 26, 1, 2, 0, 63);

    // Register 29 and memory word 12 both wrong
    set_clean(0);
    act_img[0][29]      = 32'hdead_0029;
    act_img[0][32 + 12] = 32'hdead_0044;
    run("t3_two", 0, -1, 91, 26, 2, 29, 0, 63);

    // Memory word 12 alone reports flat index 44
    set_clean(0);
    act_img[0][32 + 12] = 32'h8000_0000;
    run("t3_mem", 0, -1, 91, 26, 1, 44, 0, 63);

    // Reset mid-scan after one mismatch already counted
    set_clean(0);
    act_img[0][3] = 32'h0000_1003;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    w = 0;
    while (!(busy[0] && ea_v[0] == IW'(10)) && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("t5_reach_idx10", 32'(w < 200), 32'd1);
    check("t5_pre_count",   32'(fc_v[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_hold",  32'(hold[0]), 32'd1);
    check("t5_busy",  32'(busy[0]), 32'd0);
    check("t5_done",  32'(done[0]), 32'd0);
    check("t5_count", 32'(fc_v[0]), 32'd0);
    check("t5_first", 32'(ff_v[0]), 32'd0);
    check("t5_eaddr", 32'(sb0.exp_addr), 32'd0);
    set_clean(0);
    run("t5_rerun", 0, -1, 91, 26, 0, 0, 1, 63);

    // Stop on first fail, zero run cycles: compare of index 5 ends the scan
    act_img[1][5]  = 32'h5555_5555;
    act_img[1][40] = 32'h4040_4040;
    run("t4_stop", 1, -1, 7, 0, 1, 5, 0, 6);
    set_clean(1);
    run("t4_clean", 1, -1, 65, 0, 0, 0, 1, 63);

    // Saturating 2-bit counter, all words wrong, extra start pulse during RUN
    for (int i = 0; i < 64; i++) act_img[2][i] = ~W'(i);
    run("t6_sat", 2, 2, 69, 4, 3, 0, 0, 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
